// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for prog_fifo.
//   FwftMode / RegMode : values of the FWFT parameter selecting the read style
//   cnt_width()        : width of pointers and occupancy count for a given depth
package fifo_pkg;

   localparam int unsigned FwftMode = 1;  // head entry visible combinationally
   localparam int unsigned RegMode  = 0;  // registered read, one-cycle latency

   // One extra bit so a full FIFO (count == DEPTH) is representable and
   // pointers distinguish full from empty.
   function automatic int unsigned cnt_width(input int unsigned depth_lg2);
      return depth_lg2 + 1;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port storage array, no reset.
//   clk     : write clock (rising edge)
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : asynchronous read address
//   rdata_o : asynchronous read data
module fifo_mem #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         r_mem[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/prog_fifo.sv
// prog_fifo: synchronous FIFO with runtime-programmable almost-full/almost-empty
// thresholds, flush, sticky overflow/underflow flags and selectable read style.
//   clk, rst_n          : clock and asynchronous active-low reset
//   flush_i             : synchronous empty request, overrides same-cycle traffic
//   wren_i, wdata_i     : write request and data
//   rden_i              : read request
//   rdata_o, rvalid_o   : read data and its valid
//   full_o, empty_o     : occupancy status (registered)
//   almost_full_o/_empty_o : compare of occupancy against af_level_i / ae_level_i
//   count_o             : occupancy 0..DEPTH
//   overflow_o/underflow_o : sticky error flags, cleared by clr_err_i
module prog_fifo
   import fifo_pkg::*;
#(
   parameter int unsigned DEPTH_LG2  = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FWFT       = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush_i,
   input  logic                  wren_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  rden_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  rvalid_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic                  almost_full_o,
   output logic                  almost_empty_o,
   input  logic [DEPTH_LG2:0]    af_level_i,
   input  logic [DEPTH_LG2:0]    ae_level_i,
   output logic [DEPTH_LG2:0]    count_o,
   output logic                  overflow_o,
   output logic                  underflow_o,
   input  logic                  clr_err_i
);

   localparam int unsigned CW = cnt_width(DEPTH_LG2);
   localparam logic [CW-1:0] DepthC = CW'(2**DEPTH_LG2);

   logic [CW-1:0]         r_wptr, r_rptr, r_count;
   logic [CW-1:0]         w_wptr_nxt, w_rptr_nxt, w_count_nxt;
   logic                  r_full, r_empty, r_af, r_ae;
   logic                  r_ovf, r_unf;
   logic                  w_wr_acc, w_rd_acc;
   logic                  w_ovf_ev, w_unf_ev;
   logic [DATA_WIDTH-1:0] w_head;

   // A read frees a slot in the same cycle, so a write at full is still accepted.
   assign w_rd_acc = rden_i & ~flush_i & ~r_empty;
   assign w_wr_acc = wren_i & ~flush_i & (~r_full | w_rd_acc);
   assign w_ovf_ev = wren_i & ~w_wr_acc & ~flush_i;
   assign w_unf_ev = rden_i & ~w_rd_acc & ~flush_i;

   always_comb begin
      w_wptr_nxt  = r_wptr;
      w_rptr_nxt  = r_rptr;
      w_count_nxt = r_count;
      if (flush_i) begin
         w_wptr_nxt  = '0;
         w_rptr_nxt  = '0;
         w_count_nxt = '0;
      end else begin
         w_wptr_nxt  = r_wptr + CW'(w_wr_acc);
         w_rptr_nxt  = r_rptr + CW'(w_rd_acc);
         w_count_nxt = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
         r_af    <= 1'b0;
         r_ae    <= 1'b1;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_wptr  <= w_wptr_nxt;
         r_rptr  <= w_rptr_nxt;
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == DepthC);
         r_empty <= (w_count_nxt == '0);
         // Thresholds are sampled every cycle so level changes apply without traffic.
         r_af    <= (w_count_nxt >= af_level_i);
         r_ae    <= (w_count_nxt <= ae_level_i);
         // New error event wins over a simultaneous clear.
         r_ovf   <= w_ovf_ev | (r_ovf & ~clr_err_i);
         r_unf   <= w_unf_ev | (r_unf & ~clr_err_i);
      end
   end

   fifo_mem #(
      .ADDR_WIDTH (DEPTH_LG2),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mem (
      .clk     (clk),
      .we_i    (w_wr_acc),
      .waddr_i (r_wptr[DEPTH_LG2-1:0]),
      .wdata_i (wdata_i),
      .raddr_i (r_rptr[DEPTH_LG2-1:0]),
      .rdata_o (w_head)
   );

   generate
      if (FWFT == FwftMode) begin : g_fwft
         assign rdata_o  = w_head;
         assign rvalid_o = ~r_empty;
      end else begin : g_reg
         logic [DATA_WIDTH-1:0] r_rdata;
         logic                  r_rvalid;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_rdata  <= '0;
               r_rvalid <= 1'b0;
            end else begin
               r_rvalid <= w_rd_acc;
               if (w_rd_acc) begin
                  r_rdata <= w_head;
               end
            end
         end

         assign rdata_o  = r_rdata;
         assign rvalid_o = r_rvalid;
      end
   endgenerate

   assign count_o        = r_count;
   assign full_o         = r_full;
   assign empty_o        = r_empty;
   assign almost_full_o  = r_af;
   assign almost_empty_o = r_ae;
   assign overflow_o     = r_ovf;
   assign underflow_o    = r_unf;

endmodule

// File: tb/tb_prog_fifo.sv
// tb_prog_fifo: two prog_fifo instances (FWFT and registered read) driven by
// the same stimulus and compared against a queue-based reference model.
module tb_prog_fifo;

   localparam int unsigned LG2   = 2;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned DW    = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0, wren = 1'b0, rden = 1'b0, clr = 1'b0;
   logic [DW-1:0] wdata = '0;
   logic [LG2:0]  af_lvl = 3'd3, ae_lvl = 3'd1;

   logic [DW-1:0] rdata_f, rdata_r;
   logic          rvalid_f, rvalid_r;
   logic          full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
   logic          full_r, empty_r, af_r, ae_r, ovf_r, unf_r;
   logic [LG2:0]  count_f, count_r;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state
   logic [DW-1:0] q[$];
   logic          m_ovf = 1'b0, m_unf = 1'b0;
   logic [DW-1:0] m_rdata = '0;
   logic          m_rvalid = 1'b0;

   always #5 clk = ~clk;

   prog_fifo #(.DEPTH_LG2(LG2), .DATA_WIDTH(DW), .FWFT(1)) u_dut_f (
      .clk(clk), .rst_n(rst_n), .flush_i(flush), .wren_i(wren), .wdata_i(wdata),
      .rden_i(rden), .rdata_o(rdata_f), .rvalid_o(rvalid_f), .full_o(full_f),
      .empty_o(empty_f), .almost_full_o(af_f), .almost_empty_o(ae_f),
      .af_level_i(af_lvl), .ae_level_i(ae_lvl), .count_o(count_f),
      .overflow_o(ovf_f), .underflow_o(unf_f), .clr_err_i(clr)
   );

   prog_fifo #(.DEPTH_LG2(LG2), .DATA_WIDTH(DW), .FWFT(0)) u_dut_r (
      .clk(clk), .rst_n(rst_n), .flush_i(flush), .wren_i(wren), .wdata_i(wdata),
      .rden_i(rden), .rdata_o(rdata_r), .rvalid_o(rvalid_r), .full_o(full_r),
      .empty_o(empty_r), .almost_full_o(af_r), .almost_empty_o(ae_r),
      .af_level_i(af_lvl), .ae_level_i(ae_lvl), .count_o(count_r),
      .overflow_o(ovf_r), .underflow_o(unf_r), .clr_err_i(clr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare every status output of both instances against the model.
   task automatic check_all();
      int n = q.size();
      chk("count_f", 32'(count_f), 32'(n));
      chk("count_r", 32'(count_r), 32'(n));
      chk("full_f", 32'(full_f), 32'(n == DEPTH));
      chk("full_r", 32'(full_r), 32'(n == DEPTH));
      chk("empty_f", 32'(empty_f), 32'(n == 0));
      chk("empty_r", 32'(empty_r), 32'(n == 0));
      chk("afull_f", 32'(af_f), 32'(n >= int'(af_lvl)));
      chk("afull_r", 32'(af_r), 32'(n >= int'(af_lvl)));
      chk("aempty_f", 32'(ae_f), 32'(n <= int'(ae_lvl)));
      chk("aempty_r", 32'(ae_r), 32'(n <= int'(ae_lvl)));
      chk("ovf_f", 32'(ovf_f), 32'(m_ovf));
      chk("ovf_r", 32'(ovf_r), 32'(m_ovf));
      chk("unf_f", 32'(unf_f), 32'(m_unf));
      chk("unf_r", 32'(unf_r), 32'(m_unf));
      chk("rvalid_f", 32'(rvalid_f), 32'(n != 0));
      chk("rvalid_r", 32'(rvalid_r), 32'(m_rvalid));
      chk("rdata_r", 32'(rdata_r), 32'(m_rdata));
   endtask

   // One clock of stimulus; model is updated from the FIFO rules, then outputs checked.
   task automatic cycle(input logic wr, input logic [DW-1:0] wd, input logic rd,
                        input logic fl, input logic cl);
      int  n = q.size();
      bit  racc, wacc;
      logic [DW-1:0] popped = '0;
      wren = wr; wdata = wd; rden = rd; flush = fl; clr = cl;
      racc = rd && !fl && n > 0;
      wacc = wr && !fl && (n < DEPTH || racc);
      #1;
      if (n > 0) chk("fwft_head", 32'(rdata_f), 32'(q[0]));
      @(posedge clk);
      #1;
      m_ovf = (wr && !wacc && !fl) || (m_ovf && !cl);
      m_unf = (rd && !racc && !fl) || (m_unf && !cl);
      if (fl) begin
         q.delete();
      end else begin
         if (racc) popped = q.pop_front();
         if (wacc) q.push_back(wd);
      end
      m_rvalid = racc;
      if (racc) m_rdata = popped;
      wren = 1'b0; rden = 1'b0; flush = 1'b0; clr = 1'b0;
      check_all();
   endtask

   initial begin
      // Power-on reset
      repeat (2) @(posedge clk);
      #1;
      check_all();
      chk("rst_rdata_r", 32'(rdata_r), 32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Fill then drain in order
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // Write+read at full, then overflow, sticky until cleared
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'hB0, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 8'hBF, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // Read+write at empty: only the write is taken, underflow flagged
      cycle(1'b1, 8'hC0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

      // Threshold change with no traffic
      cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      ae_lvl = 3'd2;
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      ae_lvl = 3'd1;

      // Registered read latency
      cycle(1'b1, 8'hD0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // Flush overrides a same-cycle write and raises no error
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h3F, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // Randomized traffic with occasional threshold changes
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            af_lvl = 3'($urandom_range(0, 5));
            ae_lvl = 3'($urandom_range(0, 5));
         end
         cycle($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50,
               $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 8);
      end

      // Asynchronous reset in mid-burst, checked before any clock edge
      af_lvl = 3'd3; ae_lvl = 3'd1;
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h5F, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h5E, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #2;
      q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
      check_all();
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cycle(1'b1, 8'hE5, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
